// File: rtl/encoder_32_5_scan.sv
// Captures a 32-bit mask and streams the index of each set bit, lowest first, over a valid/ready port.
// First index appears the cycle after load; the stream stalls with all outputs held while out_ready is low.
module encoder_32_5_scan (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] mask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic [5:0]  remaining,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pending, pending_nxt;
  logic [5:0]  count, count_nxt;
  logic [4:0]  low_idx;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  // Walk downward so the lowest set bit is the last one written.
  always_comb begin
    low_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pending[i]) low_idx = 5'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      count   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    count_nxt   = count;
    out_valid   = 1'b0;
    out_idx     = '0;
    out_last    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          pending_nxt = mask;
          count_nxt   = popcount(mask);
          state_nxt   = (mask != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_idx   = low_idx;
        out_last  = (count == 6'd1);
        if (out_ready) begin
          pending_nxt = pending & ~(32'd1 << low_idx);
          count_nxt   = count - 6'd1;
          if (out_last) state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign remaining = count;

endmodule

// File: tb/tb_encoder_32_5_scan.sv
// Randomized and directed stimulus checked every cycle against a queue-based model of the index stream.
module tb_encoder_32_5_scan;

  logic        clk = 1'b0;
  logic        reset, load, out_ready;
  logic [31:0] mask;
  logic        out_valid, out_last, busy, done;
  logic [4:0]  out_idx;
  logic [5:0]  remaining;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model: indices still to emit, plus a flag for the one-cycle done pulse.
  int q[$];
  bit done_flag = 1'b0;

  always #5 clk = ~clk;

  encoder_32_5_scan dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .remaining (remaining),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
  endtask

  task automatic model_edge(input logic rst, input logic ld, input logic [31:0] m, input logic rdy);
    if (!rst) begin
      q.delete();
      done_flag = 1'b0;
    end else if (done_flag) begin
      done_flag = 1'b0;
    end else if (q.size() > 0) begin
      if (rdy) begin
        void'(q.pop_front());
        if (q.size() == 0) done_flag = 1'b1;
      end
    end else if (ld) begin
      for (int i = 0; i < 32; i++) if (m[i]) q.push_back(i);
      if (q.size() == 0) done_flag = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_idx",   32'(out_idx),   (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("out_last",  32'(out_last),  32'(q.size() == 1));
    chk("remaining", 32'(remaining), 32'(q.size()));
    chk("busy",      32'(busy),      32'((q.size() > 0) || done_flag));
    chk("done",      32'(done),      32'(done_flag));
  endtask

  task automatic run_cycle(input logic rst, input logic ld, input logic [31:0] m, input logic rdy);
    reset     = rst;
    load      = ld;
    mask      = m;
    out_ready = rdy;
    @(posedge clk);
    model_edge(rst, ld, m, rdy);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b0, 32'd0, rdy);
  endtask

  initial begin
    logic [31:0] m;
    reset = 1'b0; load = 1'b0; mask = '0; out_ready = 1'b0;
    @(negedge clk);
    run_cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0);

    // Three sparse indices including bit 31.
    run_cycle(1'b1, 1'b1, 32'h8000_0011, 1'b1);
    idle(5, 1'b1);

    // Empty mask goes straight to the done pulse.
    run_cycle(1'b1, 1'b1, 32'h0000_0000, 1'b1);
    idle(3, 1'b1);

    // Backpressure for three cycles on a single index.
    run_cycle(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // Full mask: 32 back-to-back indices, remaining starts at 32.
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    idle(36, 1'b1);

    // A load during SCAN is ignored.
    run_cycle(1'b1, 1'b1, 32'h0000_0006, 1'b1);
    run_cycle(1'b1, 1'b1, 32'hFFFF_0000, 1'b1);
    idle(4, 1'b1);

    // Reset after five transfers aborts without a done pulse.
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    idle(5, 1'b1);
    run_cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h0000_0001, 1'b1);
    idle(3, 1'b1);

    // Reset during the done pulse suppresses it.
    run_cycle(1'b1, 1'b1, 32'h0000_0000, 1'b1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    idle(2, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       m = $urandom();
        1:       m = $urandom() & $urandom() & $urandom();
        2:       m = 32'd1 << $urandom_range(0, 31);
        default: m = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd0;
      endcase
      run_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0), m,
                ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
